// File: rtl/param_updown_counter.sv
// Parameterised up/down/ping-pong counter with wrap or saturate bounds and a terminal-count pulse.
// Optional parallel load is compiled in only when CNT_LOAD_EN is defined.
module param_updown_counter #(
  parameter int WIDTH   = 5,
  parameter int MAX_VAL = 30,
  parameter int STEP    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             wrap,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             dir,
  output logic             tc
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PP   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);

  mode_e            cur_mode;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   down_diff;
  logic [WIDTH-1:0] nxt_counter;
  logic             nxt_dir;
  logic             nxt_tc;

  assign cur_mode  = mode_e'(mode);
  assign up_sum    = {1'b0, counter} + STEP_X;
  // Only consumed when counter >= STEP, so the borrow never escapes.
  assign down_diff = {1'b0, counter} - STEP_X;

  always_comb begin
    nxt_counter = counter;
    nxt_dir     = dir;
    nxt_tc      = 1'b0;
    if (en) begin
      unique case (cur_mode)
        MODE_UP: begin
          nxt_dir = 1'b1;
          if (up_sum <= MAX_X) begin
            nxt_counter = up_sum[WIDTH-1:0];
            nxt_tc      = (up_sum == MAX_X);
          end else if (wrap) begin
            nxt_counter = '0;
          end else begin
            nxt_counter = MAX_C;
            nxt_tc      = (counter != MAX_C);
          end
        end
        MODE_DOWN: begin
          nxt_dir = 1'b0;
          if ({1'b0, counter} >= STEP_X) begin
            nxt_counter = down_diff[WIDTH-1:0];
            nxt_tc      = (down_diff == '0);
          end else if (wrap) begin
            nxt_counter = MAX_C;
          end else begin
            nxt_counter = '0;
            nxt_tc      = (counter != '0);
          end
        end
        MODE_PP: begin
          if (dir) begin
            if (up_sum >= MAX_X) begin
              nxt_counter = MAX_C;
              nxt_dir     = 1'b0;
              nxt_tc      = 1'b1;
            end else begin
              nxt_counter = up_sum[WIDTH-1:0];
            end
          end else begin
            if ({1'b0, counter} <= STEP_X) begin
              nxt_counter = '0;
              nxt_dir     = 1'b1;
              nxt_tc      = 1'b1;
            end else begin
              nxt_counter = down_diff[WIDTH-1:0];
            end
          end
        end
        default: begin
          nxt_counter = counter;
        end
      endcase
    end
  end

`ifdef CNT_LOAD_EN
  logic [WIDTH-1:0] load_clamped;
  assign load_clamped = ({1'b0, load_val} > MAX_X) ? MAX_C : load_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter <= '0;
      dir     <= 1'b1;
      tc      <= 1'b0;
    end else if (load) begin
      counter <= load_clamped;
      tc      <= 1'b0;
    end else begin
      counter <= nxt_counter;
      dir     <= nxt_dir;
      tc      <= nxt_tc;
    end
  end
`else
  // Load ports stay on the boundary for pin compatibility but drive nothing.
  logic unused_load;
  assign unused_load = ^{load, load_val};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter <= '0;
      dir     <= 1'b1;
      tc      <= 1'b0;
    end else begin
      counter <= nxt_counter;
      dir     <= nxt_dir;
      tc      <= nxt_tc;
    end
  end
`endif

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 5: counter width in bits.
REQ-002 SHALL have parameter MAX_VAL, default 30: upper count bound; legal range 1 <= MAX_VAL <= 2**WIDTH-1.
REQ-003 SHALL have parameter STEP, default 1: increment/decrement amount; legal range 1 <= STEP <= MAX_VAL.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 en  input  1  count enable.
REQ-007 mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold.
REQ-008 wrap  input  1  1 = wrap at bounds, 0 = saturate (modes 00/01 only).
REQ-009 load  input  1  synchronous parallel load request.
REQ-010 load_val  input  WIDTH  value to load.
REQ-011 counter  output  WIDTH  registered count value.
REQ-012 dir  output  1  registered direction; 1 = up, 0 = down.
REQ-013 tc  output  1  registered terminal-count pulse.

Function
REQ-014 Edge priority SHALL be: reset > load > en=0 (hold) > mode action.
REQ-015 Load SHALL write min(load_val, MAX_VAL) to counter; dir and mode are unaffected; tc <= 0.
REQ-016 When en=0 or mode=11, counter and dir SHALL hold; tc <= 0.
REQ-017 All next-value arithmetic SHALL use WIDTH+1 bits; no intermediate truncation.
REQ-018 Mode 00: dir <= 1. If counter+STEP <= MAX_VAL, counter <= counter+STEP. Otherwise counter <= 0 (wrap=1) or MAX_VAL (wrap=0).
REQ-019 Mode 01: dir <= 0. If counter >= STEP, counter <= counter-STEP. Otherwise counter <= MAX_VAL (wrap=1) or 0 (wrap=0).
REQ-020 Mode 10, dir=1: if counter+STEP >= MAX_VAL, then counter <= MAX_VAL and dir <= 0; else counter <= counter+STEP.
REQ-021 Mode 10, dir=0: if counter <= STEP, then counter <= 0 and dir <= 1; else counter <= counter-STEP.
REQ-022 Ping-pong SHALL NOT dwell at a bound. Example: MAX_VAL=30, STEP=1 gives 29, 30, 29.
REQ-023 wrap SHALL be ignored in mode 10.
REQ-024 On a counting edge (not load, not hold), tc SHALL be set to 1 when the new counter equals MAX_VAL with new dir=1 or mode 10 reversal to down. It SHALL also be set to 1 when the new counter equals 0 with mode 01 or mode 10 reversal to up. Otherwise tc <= 0.
REQ-025 In wrap=0 saturation, tc SHALL pulse only on the edge the bound is first reached, and SHALL be 0 while holding at the bound.
REQ-026 Mode changes SHALL take effect on the next edge with no pipeline delay. On entry to mode 10, counting SHALL continue in the current dir.
REQ-027 Latency: an input sampled on edge N SHALL be reflected on the outputs after edge N.

Reset
REQ-028 When rst_n=0 at a rising clk edge: counter <= 0, dir <= 1, tc <= 0, regardless of all other inputs.
REQ-029 Reset asserted mid-count SHALL discard the current direction. Counting SHALL resume from 0, upward, on the first edge after rst_n=1.

Configuration
REQ-030 Macro CNT_LOAD_EN: when defined, load/load_val SHALL behave per REQ-014/REQ-015.
REQ-031 When CNT_LOAD_EN is undefined, the load and load_val ports SHALL remain, SHALL be ignored, and no load logic SHALL be synthesised.

Verification
REQ-032 Defaults, mode=00, wrap=1, en=1 for 32 cycles from reset: counter 1..30, then 0; tc high on the edge that produces 30.
REQ-033 mode=01, wrap=0, from 0: counter stays 0 and tc stays 0. Then load 5: counter 4, 3, 2, 1, 0, 0; tc high only on the edge that produces 0.
REQ-034 mode=10, MAX_VAL=30, STEP=4, from 0: counter 4, 8, ..., 28, 30(dir=0), 26, ..., 2, 0(dir=1), 4; tc high at 30 and at 0.
REQ-035 CNT_LOAD_EN defined, load_val=31 with MAX_VAL=30: counter=30, tc=0. With load and rst_n=0 on the same edge: counter=0.
REQ-036 Ping-pong at counter=17, dir=0, then rst_n low for 1 cycle: counter=0, dir=1, and the next enabled edges give 1, 2.
REQ-037 WIDTH=8, MAX_VAL=200, STEP=7, mode=00, wrap=0, from 196: counter=200 with tc=1, then 200 with tc=0.
